// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants, K table and the Sigma/sigma/Ch/Maj helpers.
// Consumed by sha256_round and sha256_round_ctrl (optional SHA256_ZERO_CHECK_EN lives in the top).
package sha256_pkg;

  localparam int WORD_W = 32;
  localparam int ROUNDS = 64;
  localparam int WORDS  = 16;
  localparam int RND_W  = $clog2(ROUNDS);

  typedef logic [WORD_W-1:0] word_t;

  // Working variables packed so that 'a' occupies the most significant word,
  // matching the H0-in-MSB ordering of the chaining value.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } hstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } fsm_state_e;

  localparam word_t K_TABLE [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Word-wise feed-forward addition; each lane wraps independently.
  function automatic hstate_t add_state(input hstate_t x, input hstate_t y);
    hstate_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// Combinational single SHA-256 round: working variables a..h plus Wt and Kt
// in, next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  hstate_t s_i,
  input  word_t   w_i,
  input  word_t   k_i,
  output hstate_t s_o
);

  word_t t1;
  word_t t2;

  // NOTE: combinational logic uses blocking '=' so t1/t2 are visible to the
  // lines that follow in the same evaluation.
  always_comb begin
    t1  = s_i.h + big_sigma1(s_i.e) + ch(s_i.e, s_i.f, s_i.g) + k_i + w_i;
    t2  = big_sigma0(s_i.a) + maj(s_i.a, s_i.b, s_i.c);
    s_o = '{a: t1 + t2, b: s_i.a, c: s_i.b, d: s_i.c,
            e: s_i.d + t1, f: s_i.e, g: s_i.f, h: s_i.g};
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: load, 64 rounds at one per clock, feed-forward.
// Optional SHA256_ZERO_CHECK_EN adds hash_zero_msw (most significant digest word == 0).
module sha256_round_ctrl
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] state_in,
  input  logic [511:0] msg_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
`ifdef SHA256_ZERO_CHECK_EN
  ,
  output logic         hash_zero_msw
`endif
);

  fsm_state_e       state_q, state_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             done_q, done_d;
  hstate_t          hash_q, hash_d;
  hstate_t          work_q, work_d;
  hstate_t          hold_q, hold_d;
  word_t            win_q [WORDS];
  word_t            win_d [WORDS];
  hstate_t          round_out;
  hstate_t          final_sum;
  word_t            new_w;
`ifdef SHA256_ZERO_CHECK_EN
  logic             zero_q, zero_d;
`endif

  sha256_round u_round (
    .s_i (work_q),
    .w_i (win_q[0]),
    .k_i (K_TABLE[rnd_q]),
    .s_o (round_out)
  );

  // Next schedule word W[t+16] while the window holds W[t]..W[t+15].
  assign new_w     = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];
  assign final_sum = add_state(hold_q, work_q);

  // NOTE: every variable gets its hold/default value first, so no path through
  // the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    hash_d  = hash_q;
    work_d  = work_q;
    hold_d  = hold_q;
    win_d   = win_q;
`ifdef SHA256_ZERO_CHECK_EN
    zero_d  = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = hstate_t'(state_in);
          hold_d  = hstate_t'(state_in);
          for (int i = 0; i < WORDS; i++) win_d[i] = msg_in[511 - 32*i -: 32];
          rnd_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d = round_out;
        for (int i = 0; i < WORDS - 1; i++) win_d[i] = win_q[i+1];
        win_d[WORDS-1] = new_w;
        rnd_d = rnd_q + 1'b1;
        if (rnd_q == RND_W'(ROUNDS - 1)) state_d = FINAL;
      end
      FINAL: begin
        hash_d  = final_sum;
        done_d  = 1'b1;
`ifdef SHA256_ZERO_CHECK_EN
        zero_d  = (final_sum.a == '0);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      done_q  <= 1'b0;
      hash_q  <= '0;
`ifdef SHA256_ZERO_CHECK_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      hash_q  <= hash_d;
`ifdef SHA256_ZERO_CHECK_EN
      zero_q  <= zero_d;
`endif
    end
  end

  // NOTE: working variables and the schedule window are always loaded before
  // use, so they carry no reset and stay plain flops/RAM-friendly.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    hold_q <= hold_d;
    win_q  <= win_d;
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hash_out = hash_q;
`ifdef SHA256_ZERO_CHECK_EN
  assign hash_zero_msw = zero_q;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: driver pushes expected digests and
// done cycles, a monitor pops and compares on every done pulse.
module tb_sha256_round_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] state_in;
  logic [511:0] msg_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;
`ifdef SHA256_ZERO_CHECK_EN
  logic         hash_zero_msw;
`endif

  sha256_round_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .state_in (state_in),
    .msg_in   (msg_in),
    .busy     (busy),
    .done     (done),
    .hash_out (hash_out)
`ifdef SHA256_ZERO_CHECK_EN
    ,
    .hash_zero_msw (hash_zero_msw)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] MSG_2B_1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] MSG_2B_2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DIG_2B    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [255:0] hash;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb_q [$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-entry schedule array, then 64 rounds.
  function automatic logic [255:0] ref_compress(input logic [255:0] st, input logic [511:0] m);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, s0, s1;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  // Called at a negedge: pulses start for one edge, then scrambles the inputs.
  task automatic issue(input logic [255:0] st, input logic [511:0] m, input logic [255:0] exp_hash);
    exp_t e;
    e.hash = exp_hash;
    e.cyc  = cyc + 66;
    sb_q.push_back(e);
    start    = 1'b1;
    state_in = st;
    msg_in   = m;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++)  state_in[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) msg_in[32*i +: 32]   = $urandom;
    check("busy_after_start", busy, 1);
  endtask

  // Returns at the negedge where done is high, or flags a timeout.
  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles required done within 100", n);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
        end else begin
          e = sb_q.pop_front();
          check("hash_out", hash_out, e.hash);
          check("done_cycle", cyc, e.cyc);
          check("busy_in_done", busy, 0);
`ifdef SHA256_ZERO_CHECK_EN
          check("hash_zero_msw", hash_zero_msw, (e.hash[255:224] == 32'h0) ? 1 : 0);
`endif
        end
      end
    end
  end

  initial begin : driver
    logic [255:0] st;
    logic [511:0] m;
    int           n;
    reset    = 1'b1;
    start    = 1'b1;
    state_in = IV;
    msg_in   = MSG_ABC;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hash", hash_out, 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    issue(IV, MSG_ABC, DIG_ABC);
    wait_done();
    issue(IV, MSG_EMPTY, DIG_EMPTY);
    wait_done();

    // Two-block chaining, second block started in the done cycle.
    issue(IV, MSG_2B_1, ref_compress(IV, MSG_2B_1));
    wait_done();
    issue(hash_out, MSG_2B_2, DIG_2B);
    wait_done();
    @(negedge clk);

    // Start while busy must be ignored.
    issue(IV, MSG_ABC, DIG_ABC);
    repeat (9) @(negedge clk);
    start    = 1'b1;
    state_in = IV;
    msg_in   = MSG_EMPTY;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Abort at round 30.
    issue(IV, MSG_ABC, DIG_ABC);
    repeat (30) @(negedge clk);
    void'(sb_q.pop_back());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hash", hash_out, 0);
    repeat (40) @(negedge clk);
    issue(IV, MSG_ABC, DIG_ABC);
    wait_done();

    // Randomized blocks, last pair back-to-back.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++)  st[32*i +: 32] = $urandom;
      for (int i = 0; i < 16; i++) m[32*i +: 32]  = $urandom;
      if (k % 2 == 0) @(negedge clk);
      issue(st, m, ref_compress(st, m));
      wait_done();
    end

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
    end
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
